// File: rtl/ysyx_24100005_mp_regfile.sv
// Multi-port register file with optional x0 hardwiring, write-to-read bypass
// and a sequential clear engine that walks every entry after reset or on request.
module ysyx_24100005_mp_regfile #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_RD      = 2,
    parameter int NR_WR      = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear_req_i,
    output logic                        ready_o,
    input  logic [NR_RD*ADDR_WIDTH-1:0] raddr_i,
    output logic [NR_RD*DATA_WIDTH-1:0] rdata_o,
    input  logic [NR_WR-1:0]            wen_i,
    input  logic [NR_WR*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NR_WR*DATA_WIDTH-1:0] wdata_i
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  ready_q, ready_d;

    logic [ADDR_WIDTH-1:0] waddr_a [NR_WR];
    logic [DATA_WIDTH-1:0] wdata_a [NR_WR];
    logic [NR_WR-1:0]      wr_ok;

    // A write to entry 0 with ZERO_REG set is treated as if it never happened,
    // both for storage and for bypass.
    generate
        for (genvar gi = 0; gi < NR_WR; gi++) begin : g_wr
            assign waddr_a[gi] = waddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_a[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign wr_ok[gi]   = wen_i[gi] && !((ZERO_REG != 0) && (waddr_a[gi] == '0));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (state_q == ST_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (clear_req_i) begin
                cnt_d = '0;
            end else if (cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
                ready_d = 1'b1;
            end
        end else if (clear_req_i) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Ascending port order makes the highest-indexed writer win on collisions.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[cnt_q] <= RESET_VAL;
            end else if (!clear_req_i) begin
                for (int j = 0; j < NR_WR; j++) begin
                    if (wr_ok[j]) begin
                        mem_q[waddr_a[j]] <= wdata_a[j];
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NR_RD; gi++) begin : g_rd
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] rd_val;

            assign ra = raddr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];

            // Checks are applied lowest priority first so later ones override.
            always_comb begin
                rd_val = mem_q[ra];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NR_WR; j++) begin
                        if (wr_ok[j] && (waddr_a[j] == ra)) begin
                            rd_val = wdata_a[j];
                        end
                    end
                end
                if (!ready_q) begin
                    rd_val = RESET_VAL;
                end
                if ((ZERO_REG != 0) && (ra == '0)) begin
                    rd_val = '0;
                end
            end

            assign rdata_o[gi*DATA_WIDTH +: DATA_WIDTH] = rd_val;
        end
    endgenerate

    assign ready_o = ready_q;

endmodule

// File: tb/tb_ysyx_24100005_mp_regfile.sv
// Scoreboard bench for the multi-port register file: expectations are queued
// when inputs are driven and compared against the DUT at the following negedge.
module tb_ysyx_24100005_mp_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear_req_i;
    logic        ready_o;
    logic [9:0]  raddr_i;
    logic [63:0] rdata_o;
    logic [1:0]  wen_i;
    logic [9:0]  waddr_i;
    logic [63:0] wdata_i;

    ysyx_24100005_mp_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req_i (clear_req_i),
        .ready_o     (ready_o),
        .raddr_i     (raddr_i),
        .rdata_o     (rdata_o),
        .wen_i       (wen_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          kind;   // 0: rdata port 0, 1: rdata port 1, 2: ready
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_txn    = 0;
    logic [31:0] mem_m [32];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic push(input string tag, input int kind, input logic [31:0] exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic set_idle();
        clear_req_i = 1'b0;
        wen_i       = 2'b00;
        waddr_i     = '0;
        wdata_i     = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        raddr_i[4:0] = a0[4:0];
        raddr_i[9:5] = a1[4:0];
    endtask

    task automatic set_wr(input int port, input int addr, input logic [31:0] data);
        wen_i[port]            = 1'b1;
        waddr_i[port*5 +: 5]   = addr[4:0];
        wdata_i[port*32 +: 32] = data;
    endtask

    // Sample at the negedge, drain the scoreboard, then advance past the posedge.
    task automatic cycle();
        logic [31:0] got;
        exp_t        e;
        @(negedge clk);
        n_txn++;
        $display("txn %0d: clr=%b wen=%b wa0=%0d wa1=%0d ra0=%0d ra1=%0d ready=%b rd0=%h rd1=%h",
                 n_txn, clear_req_i, wen_i, waddr_i[4:0], waddr_i[9:5],
                 raddr_i[4:0], raddr_i[9:5], ready_o, rdata_o[31:0], rdata_o[63:32]);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       got = rdata_o[31:0];
                1:       got = rdata_o[63:32];
                default: got = {31'b0, ready_o};
            endcase
            check_eq(e.tag, got, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        logic [31:0] r;
        if (a == 5'd0) return 32'h0;
        r = mem_m[a];
        for (int j = 0; j < 2; j++)
            if (wen_i[j] && waddr_i[j*5 +: 5] == a && waddr_i[j*5 +: 5] != 5'd0)
                r = wdata_i[j*32 +: 32];
        return r;
    endfunction

    initial begin
        rst = 1'b1;
        set_idle();
        set_rd(0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset clear: ready low for 32 sampled cycles, high after the 32nd posedge
        for (int k = 0; k < 32; k++) begin
            push("rst_ready_low", 2, 32'd0);
            set_rd(k, 31 - k);
            if (k != 0) push("rst_clear_rd0", 0, 32'h0);
            cycle();
        end
        push("rst_ready_high", 2, 32'd1);
        for (int a = 0; a < 32; a++) begin
            set_rd(a, 31 - a);
            push("init_rd0", 0, 32'h0);
            push("init_rd1", 1, 32'h0);
            cycle();
        end

        // Bypass of a single write, then the stored value
        set_idle();
        set_wr(0, 5, 32'hDEADBEEF);
        set_rd(5, 1);
        push("bypass_rd0", 0, 32'hDEADBEEF);
        push("bypass_rd1_other", 1, 32'h0);
        cycle();
        set_idle();
        push("stored_rd0", 0, 32'hDEADBEEF);
        cycle();

        // Write to x0 is discarded
        set_wr(1, 0, 32'h1234);
        set_rd(0, 0);
        push("x0_same_rd0", 0, 32'h0);
        push("x0_same_rd1", 1, 32'h0);
        cycle();
        set_idle();
        push("x0_after_rd0", 0, 32'h0);
        push("x0_after_rd1", 1, 32'h0);
        cycle();

        // Two ports writing the same entry: port 1 wins
        set_wr(0, 7, 32'hAAAA);
        set_wr(1, 7, 32'h5555);
        set_rd(7, 7);
        push("coll_same_rd0", 0, 32'h5555);
        push("coll_same_rd1", 1, 32'h5555);
        cycle();
        set_idle();
        push("coll_after_rd0", 0, 32'h5555);
        push("coll_after_rd1", 1, 32'h5555);
        cycle();

        // clear_req in RUN wipes contents and drops the same-cycle write
        set_wr(0, 3, 32'h77);
        set_rd(3, 5);
        push("x3_bypass", 0, 32'h77);
        cycle();
        set_idle();
        clear_req_i = 1'b1;
        set_wr(0, 4, 32'h99);
        set_rd(3, 7);
        push("preclr_ready", 2, 32'd1);
        push("preclr_x3", 0, 32'h77);
        push("preclr_x7", 1, 32'h5555);
        cycle();
        set_idle();
        for (int k = 0; k < 32; k++) begin
            push("clr_ready_low", 2, 32'd0);
            push("clr_rd_resetval", 0, 32'h0);
            cycle();
        end
        set_rd(3, 4);
        push("clr_ready_high", 2, 32'd1);
        push("clr_x3", 0, 32'h0);
        push("clr_x4", 1, 32'h0);
        cycle();

        // Restart of the clear engine at cnt=10, with writes issued during CLEAR
        clear_req_i = 1'b1;
        cycle();
        clear_req_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            push("rs_pre_ready_low", 2, 32'd0);
            cycle();
        end
        clear_req_i = 1'b1;
        push("rs_req_ready_low", 2, 32'd0);
        cycle();
        set_idle();
        set_rd(1, 2);
        for (int k = 0; k < 32; k++) begin
            if (k >= 5) begin
                set_wr(0, 1, 32'h1111);
                set_wr(1, 2, 32'h2222);
            end
            push("rs_ready_low", 2, 32'd0);
            push("rs_rd_resetval", 0, 32'h0);
            cycle();
        end
        set_idle();
        push("rs_ready_high", 2, 32'd1);
        push("rs_x1", 0, 32'h0);
        push("rs_x2", 1, 32'h0);
        cycle();

        // Randomised RUN traffic against a reference model of the file
        for (int a = 0; a < 32; a++) mem_m[a] = 32'h0;
        for (int k = 0; k < 60; k++) begin
            int a0, a1, r0, r1;
            set_idle();
            a0 = $urandom_range(0, 31);
            a1 = ($urandom_range(0, 3) == 0) ? a0 : $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) set_wr(0, a0, $urandom);
            if ($urandom_range(0, 1) == 1) set_wr(1, a1, $urandom);
            r0 = ($urandom_range(0, 1) == 1) ? a0 : $urandom_range(0, 31);
            r1 = ($urandom_range(0, 1) == 1) ? a1 : $urandom_range(0, 31);
            set_rd(r0, r1);
            push("rnd_rd0", 0, model_rd(raddr_i[4:0]));
            push("rnd_rd1", 1, model_rd(raddr_i[9:5]));
            for (int j = 0; j < 2; j++)
                if (wen_i[j] && waddr_i[j*5 +: 5] != 5'd0)
                    mem_m[waddr_i[j*5 +: 5]] = wdata_i[j*32 +: 32];
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
